tanh_result_serializer: RTL and testbench
=========================================

# tanh_result_serializer

Reads the packed result vector produced by the tanh activation array once that array raises its finished flag. Splits the vector into individual IEEE-754 single-precision elements and streams them out one per handshake over a valid/ready interface. After the last element has been accepted, it pulses a restart request to the upstream control. It is the consumer end of the tanh array's packed-output/finished interface and feeds the next layer or the result buffer.

## Interface
- DATA_WIDTH, 32: width of one float element.
- N, 2: number of elements in the packed vector.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- packed_in  in  N*DATA_WIDTH  tanh array result vector. Element 0 occupies bits [N*DATA_WIDTH-1 -: DATA_WIDTH]; element k occupies the next lower slice.
- finished_in  in  1  tanh array finished flag. Level signal; stays high until upstream is reset.
- out_data  out  DATA_WIDTH  current element.
- out_index  out  $clog2(N) (min 1)  index of the current element.
- out_valid  out  1  out_data/out_index are valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  high with out_valid on element N-1.
- busy  out  1  a vector is captured and not yet fully streamed.
- restart  out  1  one-cycle pulse after the final element is accepted.
- overrun  out  1  sticky flag; a new finished edge arrived while busy.

## Operation
- Edge detection: a registered copy of finished_in. Start condition = finished_in & ~finished_q.
- FSM states:
  - IDLE → STREAM on start: latch packed_in into the capture register, index=0.
  - STREAM: out_valid=1. On out_valid&out_ready:
    - if index==N-1 → DONE;
    - else index+1, next element.
  - DONE: restart=1 for exactly one cycle → IDLE.
- Data is taken only from the capture register. Changes on packed_in after capture do not affect the streamed values.
- A start seen in STREAM or DONE is dropped and sets overrun. overrun clears only on reset.
- A start seen in the same cycle the FSM enters IDLE is not seen by IDLE. finished_in must fall and rise again before the next capture.
- busy = (state != IDLE).
- out_last = out_valid & (index==N-1).
- No arithmetic on the data; bits pass through unchanged.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system) drives every output to 0:
  - out_data=0, out_index=0, out_valid=0, out_last=0, busy=0, restart=0, overrun=0;
  - state=IDLE, finished_q=0, capture register=0.
- Reset mid-stream aborts immediately; no restart pulse is issued.
- Latency: start edge on cycle t → out_valid=1 from cycle t+1 with element 0.
- With out_ready held high: element k is transferred on cycle t+1+k, restart is high on cycle t+1+N, and busy falls on cycle t+2+N.
- While out_valid=1 and out_ready=0: out_data, out_index and out_last hold stable and out_valid stays high.
- out_valid never depends combinationally on out_ready.
- finished_in already high when reset deasserts: finished_q=0 after reset, so this counts as an edge and is captured on the first clock.

## Structure
- Shared package tanh_pkg:
  - DATA_WIDTH default constant;
  - vector element count;
  - state enum {IDLE, STREAM, DONE}.
- One natural sub-module: rise_detect (register plus AND-NOT), reused by other finished-flag consumers.
- The element mux is indexed slicing of the capture register; no sub-module.

## Test plan
- Reset, then finished_in 0→1 with packed_in=0x3F096F7B_3F800000 and out_ready=1:
  - out_data=0x3F096F7B (index 0) on t+1;
  - 0x3F800000 (index 1, out_last=1) on t+2;
  - restart pulse on t+3;
  - busy=0 on t+4.
- Same stimulus, out_ready low for 3 cycles after out_valid rises: out_data stays 0x3F096F7B with valid high; transfer on the first ready cycle; order preserved.
- packed_in changed to 0xFFFFFFFF_FFFFFFFF on the cycle after capture: streamed values are still 0x3F096F7B, 0x3F800000.
- finished_in pulsed low then high while streaming: overrun=1, and the stream and restart are unaffected.
- Reset asserted while index=1 and out_ready=0: all outputs are 0 immediately, and no restart pulse occurs.
- finished_in held high across reset deassert: capture occurs on the first clock, and element 0 appears on the second clock.

Source files
------------

// File: rtl/tanh_pkg.sv
// Shared constants and types for consumers of the tanh activation array's packed output.
package tanh_pkg;

    localparam int unsigned TANH_DATA_WIDTH = 32;
    localparam int unsigned TANH_N_ELEM     = 2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } ser_state_e;

    // Index width for an n-element vector, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for level-style handshake flags.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_o,
    output logic level_q_o
);

    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o    = level_i & ~level_q;
    assign level_q_o = level_q;

endmodule

// File: rtl/tanh_result_serializer.sv
// Captures the tanh array's packed result on its finished edge and streams the elements
// out one per valid/ready handshake, then pulses restart to the upstream control.
module tanh_result_serializer
    import tanh_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TANH_DATA_WIDTH,
    parameter int unsigned N          = TANH_N_ELEM,
    localparam int unsigned IDX_W     = idx_width(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N*DATA_WIDTH-1:0] packed_in,
    input  logic                  finished_in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  restart,
    output logic                  overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    ser_state_e              state_q;
    logic [IDX_W-1:0]        index_q;
    logic [N*DATA_WIDTH-1:0] capture_q;
    logic                    overrun_q;
    logic                    start;
    logic                    finished_q;
    logic [DATA_WIDTH-1:0]   elem;

    rise_detect u_rise_detect (
        .clk       (clk),
        .reset     (reset),
        .level_i   (finished_in),
        .rise_o    (start),
        .level_q_o (finished_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            capture_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            // Any edge outside IDLE is lost, including the one on the DONE->IDLE cycle.
            if (start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        capture_q <= packed_in;
                        index_q   <= '0;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (index_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            index_q <= index_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    index_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Element 0 sits in the most significant slice of the vector.
    always_comb begin
        elem = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (index_q == IDX_W'(k)) begin
                elem = capture_q[(int'(N) - 1 - k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_valid = (state_q == STREAM);
    assign out_data  = out_valid ? elem : '0;
    assign out_index = out_valid ? index_q : '0;
    assign out_last  = out_valid && (index_q == LAST_IDX);
    assign busy      = (state_q != IDLE);
    assign restart   = (state_q == DONE);
    assign overrun   = overrun_q;

    logic unused_finished_q;
    assign unused_finished_q = finished_q;

endmodule

// File: tb/tb_tanh_result_serializer.sv
// Directed, table-driven bench for tanh_result_serializer with N=2 single-precision elements.
module tb_tanh_result_serializer;

    localparam logic [63:0] VEC_A = 64'h3F096F7B_3F800000;
    localparam logic [31:0] E0    = 32'h3F096F7B;
    localparam logic [31:0] E1    = 32'h3F800000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] packed_in;
    logic        finished_in;
    logic [31:0] out_data;
    logic [0:0]  out_index;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        restart;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fin;
        logic        rdy;
        logic        v;
        logic [31:0] d;
        logic        i;
        logic        l;
        logic        b;
        logic        r;
        logic        o;
    } vec_t;

    vec_t tbl[$];

    tanh_result_serializer #(
        .DATA_WIDTH (32),
        .N          (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .packed_in   (packed_in),
        .finished_in (finished_in),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .restart     (restart),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Observed output bundle: {valid, data, index, last, busy, restart, overrun}.
    function automatic logic [37:0] obs();
        return {out_valid, out_data, out_index, out_last, busy, restart, overrun};
    endfunction

    function automatic logic [37:0] ex(input logic v, input logic [31:0] d, input logic i,
                                       input logic l, input logic b, input logic r,
                                       input logic o);
        return {v, d, i, l, b, r, o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic fin, input logic rdy, input logic v, input logic [31:0] d,
                       input logic i, input logic l, input logic b, input logic r,
                       input logic o);
        vec_t t;
        t.fin = fin; t.rdy = rdy; t.v = v; t.d = d; t.i = i;
        t.l = l; t.b = b; t.r = r; t.o = o;
        tbl.push_back(t);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Basic stream with ready high, then ready held low for three cycles.
        add(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        add(1, 1, 1, E0,    0, 0, 1, 0, 0);
        add(1, 1, 1, E1,    1, 1, 1, 0, 0);
        add(1, 1, 0, 32'h0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        add(1, 0, 1, E0,    0, 0, 1, 0, 0);
        add(1, 0, 1, E0,    0, 0, 1, 0, 0);
        add(1, 0, 1, E0,    0, 0, 1, 0, 0);
        add(1, 1, 1, E0,    0, 0, 1, 0, 0);
        add(1, 1, 1, E1,    1, 1, 1, 0, 0);
        add(1, 1, 0, 32'h0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);

        reset       = 1'b1;
        packed_in   = VEC_A;
        finished_in = 1'b0;
        out_ready   = 1'b1;
        #2;
        check("reset_outputs", {26'h0, obs()}, 64'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        foreach (tbl[n]) begin
            finished_in = tbl[n].fin;
            out_ready   = tbl[n].rdy;
            @(negedge clk);
            check($sformatf("table_row_%0d", n), {26'h0, obs()},
                  {26'h0, ex(tbl[n].v, tbl[n].d, tbl[n].i, tbl[n].l, tbl[n].b, tbl[n].r,
                             tbl[n].o)});
            next_cycle();
        end

        // packed_in changes right after capture must not reach the stream.
        finished_in = 1'b1;
        out_ready   = 1'b1;
        next_cycle();
        packed_in = 64'hFFFFFFFF_FFFFFFFF;
        @(negedge clk);
        check("hold_elem0", {26'h0, obs()}, {26'h0, ex(1, E0, 0, 0, 1, 0, 0)});
        next_cycle();
        @(negedge clk);
        check("hold_elem1", {26'h0, obs()}, {26'h0, ex(1, E1, 1, 1, 1, 0, 0)});
        next_cycle();
        @(negedge clk);
        check("hold_restart", {26'h0, obs()}, {26'h0, ex(0, 0, 0, 0, 1, 1, 0)});
        next_cycle();
        finished_in = 1'b0;
        packed_in   = VEC_A;
        @(negedge clk);
        check("hold_idle", {26'h0, obs()}, 64'h0);
        next_cycle();

        // Second finished edge while streaming sets overrun and leaves the stream alone.
        finished_in = 1'b1;
        out_ready   = 1'b0;
        next_cycle();
        finished_in = 1'b0;
        next_cycle();
        finished_in = 1'b1;
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        check("ovr_set", {26'h0, obs()}, {26'h0, ex(1, E0, 0, 0, 1, 0, 1)});
        next_cycle();
        @(negedge clk);
        check("ovr_elem1", {26'h0, obs()}, {26'h0, ex(1, E1, 1, 1, 1, 0, 1)});
        next_cycle();
        @(negedge clk);
        check("ovr_restart", {26'h0, obs()}, {26'h0, ex(0, 0, 0, 0, 1, 1, 1)});
        next_cycle();
        finished_in = 1'b0;
        @(negedge clk);
        check("ovr_sticky", {26'h0, obs()}, {26'h0, ex(0, 0, 0, 0, 0, 0, 1)});
        next_cycle();

        // Reset while element 1 is stalled aborts without a restart pulse.
        finished_in = 1'b1;
        out_ready   = 1'b1;
        next_cycle();
        next_cycle();
        out_ready = 1'b0;
        @(negedge clk);
        check("abort_pre", {26'h0, obs()}, {26'h0, ex(1, E1, 1, 1, 1, 0, 1)});
        #2;
        reset       = 1'b1;
        finished_in = 1'b0;
        #1;
        check("abort_async", {26'h0, obs()}, 64'h0);
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("abort_no_restart_%0d", c), {62'h0, restart, busy}, 64'h0);
            next_cycle();
        end

        // finished_in already high when reset releases counts as an edge.
        reset       = 1'b1;
        finished_in = 1'b1;
        out_ready   = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rel_pre", {26'h0, obs()}, 64'h0);
        next_cycle();
        @(negedge clk);
        check("rel_elem0", {26'h0, obs()}, {26'h0, ex(1, E0, 0, 0, 1, 0, 0)});
        next_cycle();
        @(negedge clk);
        check("rel_elem1", {26'h0, obs()}, {26'h0, ex(1, E1, 1, 1, 1, 0, 0)});
        next_cycle();
        @(negedge clk);
        check("rel_restart", {26'h0, obs()}, {26'h0, ex(0, 0, 0, 0, 1, 1, 0)});
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
